// File: rtl/sdf_bf_stage_16.sv
// Radix-2 SDF butterfly stage, span 16, for the 32-point FFT.
// Define SDF_BF_SAT_EN to saturate the butterfly and multiply results.
module sdf_bf_stage_16 #(
    parameter int DW   = 24,
    parameter int FRAC = 8,
    parameter int SPAN = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] din_r,
    input  logic signed [DW-1:0] din_i,
    input  logic signed [DW-1:0] w_r,
    input  logic signed [DW-1:0] w_i,
    output logic signed [DW-1:0] dout_r,
    output logic signed [DW-1:0] dout_i,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CW = $clog2(3 * SPAN);
    localparam int PW = 2 * DW + 1;
    localparam logic [CW-1:0] K_BF   = CW'(SPAN);
    localparam logic [CW-1:0] K_MUL  = CW'(2 * SPAN);
    localparam logic [CW-1:0] K_LAST = CW'(3 * SPAN - 1);

    logic [CW-1:0]        r_count;
    logic                 r_busy;
    logic signed [DW-1:0] r_dout_r;
    logic signed [DW-1:0] r_dout_i;
    logic                 r_ov;
    logic                 r_fd;
    logic signed [DW-1:0] r_dl_r [SPAN];
    logic signed [DW-1:0] r_dl_i [SPAN];

    logic                 w_run;
    logic                 w_fill;
    logic                 w_bfly;
    logic                 w_mult;
    logic                 w_last;
    logic signed [DW-1:0] w_a_r;
    logic signed [DW-1:0] w_a_i;
    logic signed [DW-1:0] w_sum_r;
    logic signed [DW-1:0] w_sum_i;
    logic signed [DW-1:0] w_dif_r;
    logic signed [DW-1:0] w_dif_i;
    logic signed [DW-1:0] w_mul_r;
    logic signed [DW-1:0] w_mul_i;
    logic signed [DW-1:0] w_dl_in_r;
    logic signed [DW-1:0] w_dl_in_i;
    logic signed [2*DW-1:0] w_p_rr;
    logic signed [2*DW-1:0] w_p_ii;
    logic signed [2*DW-1:0] w_p_ri;
    logic signed [2*DW-1:0] w_p_ir;
    logic signed [PW-1:0]   w_m_r;
    logic signed [PW-1:0]   w_m_i;

    // The counter is 0 while idle, so an idle in_valid is cycle k=0.
    assign w_run  = r_busy | in_valid;
    assign w_fill = w_run && (r_count < K_BF);
    assign w_bfly = w_run && (r_count >= K_BF) && (r_count < K_MUL);
    assign w_mult = w_run && (r_count >= K_MUL);
    assign w_last = r_busy && (r_count == K_LAST);

    assign w_a_r = r_dl_r[SPAN-1];
    assign w_a_i = r_dl_i[SPAN-1];

    assign w_p_rr = w_a_r * w_r;
    assign w_p_ii = w_a_i * w_i;
    assign w_p_ri = w_a_r * w_i;
    assign w_p_ir = w_a_i * w_r;
    assign w_m_r  = {w_p_rr[2*DW-1], w_p_rr} - {w_p_ii[2*DW-1], w_p_ii};
    assign w_m_i  = {w_p_ri[2*DW-1], w_p_ri} + {w_p_ir[2*DW-1], w_p_ir};

`ifdef SDF_BF_SAT_EN
    localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    function automatic logic signed [DW-1:0] sat_add(
        input logic signed [DW:0] v
    );
        if (v[DW] == v[DW-1]) return v[DW-1:0];
        else if (v[DW])       return MINV;
        else                  return MAXV;
    endfunction

    function automatic logic signed [DW-1:0] sat_mul(
        input logic signed [PW-1:0] v
    );
        if ((v[PW-1:DW-1] == '0) || (v[PW-1:DW-1] == '1))
            return v[DW-1:0];
        else if (v[PW-1])
            return MINV;
        else
            return MAXV;
    endfunction

    logic signed [DW:0]   w_xs_r;
    logic signed [DW:0]   w_xs_i;
    logic signed [DW:0]   w_xd_r;
    logic signed [DW:0]   w_xd_i;
    logic signed [PW-1:0] w_sh_r;
    logic signed [PW-1:0] w_sh_i;

    assign w_xs_r  = {w_a_r[DW-1], w_a_r} + {din_r[DW-1], din_r};
    assign w_xs_i  = {w_a_i[DW-1], w_a_i} + {din_i[DW-1], din_i};
    assign w_xd_r  = {w_a_r[DW-1], w_a_r} - {din_r[DW-1], din_r};
    assign w_xd_i  = {w_a_i[DW-1], w_a_i} - {din_i[DW-1], din_i};
    assign w_sum_r = sat_add(w_xs_r);
    assign w_sum_i = sat_add(w_xs_i);
    assign w_dif_r = sat_add(w_xd_r);
    assign w_dif_i = sat_add(w_xd_i);
    assign w_sh_r  = w_m_r >>> FRAC;
    assign w_sh_i  = w_m_i >>> FRAC;
    assign w_mul_r = sat_mul(w_sh_r);
    assign w_mul_i = sat_mul(w_sh_i);
`else
    assign w_sum_r = w_a_r + din_r;
    assign w_sum_i = w_a_i + din_i;
    assign w_dif_r = w_a_r - din_r;
    assign w_dif_i = w_a_i - din_i;
    assign w_mul_r = DW'(w_m_r >>> FRAC);
    assign w_mul_i = DW'(w_m_i >>> FRAC);
`endif

    // Samples fill the line, differences replace them, zeros flush it.
    always_comb begin
        w_dl_in_r = '0;
        w_dl_in_i = '0;
        if (w_fill) begin
            w_dl_in_r = din_r;
            w_dl_in_i = din_i;
        end else if (w_bfly) begin
            w_dl_in_r = w_dif_r;
            w_dl_in_i = w_dif_i;
        end
    end

    // Delay line shifts once per frame cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < SPAN; j++) begin
                r_dl_r[j] <= '0;
                r_dl_i[j] <= '0;
            end
        end else if (w_run) begin
            r_dl_r[0] <= w_dl_in_r;
            r_dl_i[0] <= w_dl_in_i;
            for (int j = 1; j < SPAN; j++) begin
                r_dl_r[j] <= r_dl_r[j-1];
                r_dl_i[j] <= r_dl_i[j-1];
            end
        end
    end

    // Frame sequencing: cycle counter and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (w_run) begin
            if (w_last) begin
                r_count <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_count <= r_count + 1'b1;
                r_busy  <= 1'b1;
            end
        end
    end

    // Registered results; dout holds while out_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout_r <= '0;
            r_dout_i <= '0;
            r_ov     <= 1'b0;
            r_fd     <= 1'b0;
        end else begin
            r_ov <= w_bfly | w_mult;
            r_fd <= w_last;
            if (w_bfly) begin
                r_dout_r <= w_sum_r;
                r_dout_i <= w_sum_i;
            end else if (w_mult) begin
                r_dout_r <= w_mul_r;
                r_dout_i <= w_mul_i;
            end
        end
    end

    assign dout_r     = r_dout_r;
    assign dout_i     = r_dout_i;
    assign out_valid  = r_ov;
    assign busy       = r_busy;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_sdf_bf_stage_16.sv
// Directed-vector bench for sdf_bf_stage_16.
// Expected values are hand-computed per frame.
module tb_sdf_bf_stage_16;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] din_r, din_i, w_r, w_i;
    logic [DW-1:0] dout_r, dout_i;
    logic          out_valid, busy, frame_done;

    sdf_bf_stage_16 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .din_r(din_r), .din_i(din_i), .w_r(w_r), .w_i(w_i),
        .dout_r(dout_r), .dout_i(dout_i), .out_valid(out_valid),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    int twr [16] = '{256, 251, 237, 213, 181, 142, 98, 50,
                     0, -50, -98, -142, -181, -213, -237, -251};
    int twi [16] = '{0, -50, -98, -142, -181, -213, -237, -251,
                     -256, -251, -237, -213, -181, -142, -98, -50};

    logic [DW-1:0] xr [32];
    logic [DW-1:0] xi [32];
    logic [DW-1:0] er [64];
    logic [DW-1:0] ei [64];
    logic          ev [64];
    logic          ef [64];
    logic [DW-1:0] gr [64];
    logic [DW-1:0] gi [64];
    logic          gv [64];
    logic          gf [64];
    logic          gb [64];

    task automatic chk(input string tag, input int c,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc %0d: observed %h expected %h",
                   tag, c, got, exp);
        end
    endtask

    task automatic clear_x();
        for (int k = 0; k < 32; k++) begin
            xr[k] = '0;
            xi[k] = '0;
        end
    endtask

    task automatic clear_exp();
        for (int c = 0; c < 64; c++) begin
            er[c] = '0;
            ei[c] = '0;
            ev[c] = (c >= 17) && (c <= 48);
            ef[c] = (c == 48);
        end
    endtask

    // k=0 is the cycle with in_valid; record[k+1] is state after its edge.
    task automatic run_frame(input int rst_at, input int pulse_at,
                             input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            reset    = (k == rst_at);
            in_valid = (k == 0) || (k == pulse_at);
            if (k < 32) begin
                din_r = xr[k];
                din_i = xi[k];
            end else begin
                din_r = 24'h5A5A5A;
                din_i = 24'hA5A5A5;
            end
            if (k >= 32 && k < 48) begin
                w_r = DW'(twr[k-32]);
                w_i = DW'(twi[k-32]);
            end else begin
                w_r = 24'h3C3C3C;
                w_i = 24'hC3C3C3;
            end
            @(posedge clk);
            #1;
            gr[k+1] = dout_r;
            gi[k+1] = dout_i;
            gv[k+1] = out_valid;
            gf[k+1] = frame_done;
            gb[k+1] = busy;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int last);
        for (int c = 1; c <= last; c++) begin
            chk({tag, ".ov"}, c, DW'(gv[c]), DW'(ev[c]));
            chk({tag, ".fd"}, c, DW'(gf[c]), DW'(ef[c]));
            if (ev[c]) begin
                chk({tag, ".re"}, c, gr[c], er[c]);
                chk({tag, ".im"}, c, gi[c], ei[c]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        din_r    = '0;
        din_i    = '0;
        w_r      = '0;
        w_i      = '0;
        idle(2);
        chk("rst.re", 0, dout_r, '0);
        chk("rst.im", 0, dout_i, '0);
        chk("rst.ov", 0, DW'(out_valid), '0);
        chk("rst.busy", 0, DW'(busy), '0);
        chk("rst.fd", 0, DW'(frame_done), '0);
        reset = 1'b0;
        idle(2);

        // Impulse at x[0].
        clear_x();
        xr[0] = 24'd256;
        clear_exp();
        er[17] = 24'd256;
        er[33] = 24'd256;
        run_frame(-1, -1, 49);
        check_frame("imp", 48);
        chk("imp.busy", 1, DW'(gb[1]), 24'd1);
        chk("imp.busy", 47, DW'(gb[47]), 24'd1);
        chk("imp.busy", 48, DW'(gb[48]), 24'd0);
        chk("imp.ov", 49, DW'(gv[49]), 24'd0);
        chk("imp.fd", 49, DW'(gf[49]), 24'd0);
        chk("imp.hold", 49, gr[49], 24'd0);
        idle(3);

        // Shifted impulses; cross terms, floor shift, mid-frame pulse.
        clear_x();
        xr[1] = 24'd256;
        xr[2] = 24'd256;
        xi[2] = 24'd256;
        xr[3] = 24'd1;
        clear_exp();
        er[18] = 24'd256;
        er[19] = 24'd256;
        ei[19] = 24'd256;
        er[20] = 24'd1;
        er[34] = 24'd251;
        ei[34] = -24'sd50;
        er[35] = 24'd335;
        ei[35] = 24'd139;
        er[36] = 24'd0;
        ei[36] = -24'sd1;
        run_frame(-1, 20, 49);
        check_frame("shf", 49);
        idle(3);

        // Constant input.
        for (int k = 0; k < 32; k++) begin
            xr[k] = 24'd256;
            xi[k] = 24'd256;
        end
        clear_exp();
        for (int c = 17; c <= 32; c++) begin
            er[c] = 24'd512;
            ei[c] = 24'd512;
        end
        run_frame(-1, -1, 49);
        check_frame("cst", 49);
        idle(3);

        // Overflow on add and subtract.
        clear_x();
        xr[0]  = 24'h7FFFFF;
        xi[0]  = 24'h800000;
        xr[16] = 24'h7FFFFF;
        xi[16] = 24'h000001;
        clear_exp();
        ei[17] = 24'h800001;
`ifdef SDF_BF_SAT_EN
        er[17] = 24'h7FFFFF;
        ei[33] = 24'h800000;
`else
        er[17] = 24'hFFFFFE;
        ei[33] = 24'h7FFFFF;
`endif
        run_frame(-1, -1, 49);
        check_frame("ovf", 48);
        idle(3);

        // Reset in cycle 25 discards the frame.
        clear_x();
        xr[0] = 24'd256;
        clear_exp();
        for (int c = 26; c < 64; c++) begin
            ev[c] = 1'b0;
            ef[c] = 1'b0;
        end
        er[17] = 24'd256;
        run_frame(25, -1, 50);
        check_frame("rst", 50);
        chk("rst.re", 26, gr[26], '0);
        chk("rst.im", 26, gi[26], '0);
        chk("rst.busy", 26, DW'(gb[26]), '0);
        idle(2);

        // Clean impulse after reset.
        clear_x();
        xr[0] = 24'd256;
        clear_exp();
        er[17] = 24'd256;
        er[33] = 24'd256;
        run_frame(-1, -1, 49);
        check_frame("post", 48);
        idle(3);

        // Back-to-back: constant frame, then impulse at cycle 48.
        for (int k = 0; k < 32; k++) begin
            xr[k] = 24'd256;
            xi[k] = 24'd256;
        end
        clear_exp();
        for (int c = 17; c <= 32; c++) begin
            er[c] = 24'd512;
            ei[c] = 24'd512;
        end
        run_frame(-1, -1, 48);
        check_frame("b2bA", 48);
        clear_x();
        xr[0] = 24'd256;
        clear_exp();
        er[17] = 24'd256;
        er[33] = 24'd256;
        run_frame(-1, -1, 49);
        check_frame("b2bB", 49);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sdf_bf_stage_16.md
Name: sdf_bf_stage_16

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage, span 16, for the 32-point FFT datapath.
- Consumes one 32-sample complex frame.
- Emits the 16 butterfly sums, then the 16 butterfly differences multiplied by the twiddle pair presented on w_r/w_i.
- Twiddles come from the companion span-16 twiddle ROM, which is driven by the same in_valid. The ROM's count therefore equals this stage's cycle index k.

Parameters:
- DW, 24, sample and twiddle word width; signed two's complement, Q(DW-8).8 (256 = 1.0).
- FRAC, 8, fractional bits; product right-shift amount.
- SPAN, 16, delay-line depth and half-frame length.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  frame start / sample qualifier
- din_r  input  DW  sample real part
- din_i  input  DW  sample imaginary part
- w_r  input  DW  twiddle real part; used in cycles k=32..47 only
- w_i  input  DW  twiddle imaginary part; used in cycles k=32..47 only
- dout_r  output  DW  result real part (registered)
- dout_i  output  DW  result imaginary part (registered)
- out_valid  output  1  dout qualifier (registered)
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse with the last output

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high.
- Reset values: dout_r=0, dout_i=0, out_valid=0, busy=0, frame_done=0, count=0, delay line cleared.
- IDLE: count=0, busy=0. The first cycle with in_valid=1 is cycle k=0 and starts the frame: busy=1 from the next cycle, count increments every cycle.
- Once started, the counter advances every cycle regardless of in_valid. din is sampled in every cycle k=0..31 whether or not in_valid is high.
- Phase FILL (k=0..15): write din into the 16-deep delay line (shift register of DW*2 bits). Outputs hold out_valid=0.
- Phase BFLY (k=16..31): a = delay head (x[k-16]), b = din (x[k]).
  - Register dout = a+b, out_valid=1 next cycle.
  - Shift a-b into the delay line.
- Phase MULT (k=32..47): d = delay head (difference k-32); din and in_valid are ignored.
  - Register dout = d*w, out_valid=1 next cycle.
  - Expected twiddle is w = W32^(k-32) = exp(-j*2*pi*(k-32)/32).
- Complex multiply: re = d_r*w_r - d_i*w_i, im = d_r*w_i + d_i*w_r.
  - Full 2*DW+1-bit signed intermediates.
  - Arithmetic shift right by FRAC (truncate toward -inf), then keep the low DW bits.
- Add/sub in BFLY: DW-bit two's-complement wrap (see optional feature).
- Latency: dout for cycle k appears at cycle k+1. out_valid is high for exactly 32 consecutive cycles, k+1 = 17..48.
- After k=47: count returns to 0 and busy=0 at cycle 48. frame_done=1 in cycle 48, coincident with the last out_valid.
- in_valid=1 in cycle 48 or later starts a new frame. in_valid during a busy frame does not restart it.
- When out_valid=0, dout holds its last value.
- Reset mid-frame: all state returns to reset values on the next edge; the frame is discarded and no frame_done is issued.

Optional Feature:
- SDF_BF_SAT_EN defined: BFLY a+b and a-b saturate to [-2^(DW-1), 2^(DW-1)-1]. The complex multiply result also saturates to DW bits instead of truncating its upper bits.
- Undefined: plain two's-complement wrap on all of the above.

Test Plan:
- Impulse: x[0]=256+j0, all other samples 0, w driven from the W32 table -> dout at cycle 17 = 256; cycles 18..32 = 0; cycle 33 = 256+j0; cycles 34..48 = 0; frame_done only at cycle 48.
- Shifted impulse: x[1]=256 -> cycle 18 dout=256; cycle 34 dout = 251 - j50 (w = 251 - j50).
- Constant: all x=256+j256 -> cycles 17..32 dout = 512+j512; cycles 33..48 dout = 0; out_valid high for exactly 32 cycles.
- Overflow: x[0]=x[16]=0x7FFFFF real -> cycle 17 dout_r = 0x7FFFFF with SDF_BF_SAT_EN, 0xFFFFFE without.
- Reset at cycle 25 -> next cycle all outputs 0, busy=0, no frame_done. A new in_valid then yields a correct impulse frame.
- Back-to-back: in_valid at cycle 48 -> second frame outputs start at cycle 65 with no corruption from frame 1. in_valid pulsed mid-frame -> ignored.
